// File: rtl/imm_ext_pkg.sv
// Shared definitions for immediate extension: mode encoding and width legality check.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO   = 2'd0,
    EXT_SIGN   = 2'd1,
    EXT_UPPER  = 2'd2,
    EXT_BRANCH = 2'd3
  } ext_mode_t;

  // Branch mode shifts left by 2, so the output needs two bits of headroom.
  localparam int unsigned EXT_MARGIN = 2;

  function automatic bit ext_width_ok(int unsigned in_w, int unsigned out_w);
    return out_w >= in_w + EXT_MARGIN;
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational IN_W->OUT_W immediate extender selected by mode.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] ext_c
);

  localparam int unsigned PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sign_c;

  assign sign_c = {{PAD_W{imm[IN_W-1]}}, imm};

  always_comb begin
    ext_c = '0;
    case (mode)
      EXT_ZERO:   ext_c = OUT_W'(imm);
      EXT_SIGN:   ext_c = sign_c;
      EXT_UPPER:  ext_c = OUT_W'(imm) << PAD_W;
      EXT_BRANCH: ext_c = sign_c << 2;
      default:    ext_c = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage: extends at push, holds up to two entries
// (head in slot 0) with a sideband tag, valid/ready handshake and flush.
module imm_extend_stage
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  if (!ext_width_ok(IN_W, OUT_W)) begin : g_width_check
    $error("imm_extend_stage: OUT_W must be at least IN_W+2");
  end

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2);

  logic [OUT_W-1:0] ext_c;
  logic [OUT_W-1:0] data_q [2];
  logic [TAG_W-1:0] tag_q  [2];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push;
  logic             pop;
  logic             load_head;
  logic             load_tail;
  logic             shift;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm   (in_imm),
    .mode  (ext_mode_t'(in_mode)),
    .ext_c (ext_c)
  );

  // Ready depends only on the registered count (and reset), never on out_ready.
  assign in_ready  = rst && (count_q < DEPTH);
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? data_q[0] : '0;
  assign out_tag   = out_valid ? tag_q[0]  : '0;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Slot update decode; push+pop only coexist at count 1, where the new entry becomes head.
  always_comb begin
    count_d   = count_q;
    load_head = 1'b0;
    load_tail = 1'b0;
    shift     = 1'b0;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d   = count_q + CNT_W'(1);
      load_head = (count_q == '0);
      load_tail = (count_q != '0);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
      shift   = 1'b1;
    end else if (push && pop) begin
      load_head = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q   <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
    end else begin
      count_q <= count_d;
      if (load_head) begin
        data_q[0] <= ext_c;
        tag_q[0]  <= in_tag;
      end else if (shift) begin
        data_q[0] <= data_q[1];
        tag_q[0]  <= tag_q[1];
      end
      if (load_tail) begin
        data_q[1] <= ext_c;
        tag_q[1]  <= in_tag;
      end
    end
  end

endmodule
